// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: resolution mode encodings
// and the Gray-code step lookup used by every channel.
package quad_pkg;

  // Decode resolution selected by the mode input; 2'b11 also decodes as x4.
  localparam logic [1:0] MODE_X1 = 2'b00;
  localparam logic [1:0] MODE_X2 = 2'b01;
  localparam logic [1:0] MODE_X4 = 2'b10;

  // Classification of one transition between two debounced {A,B} states.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_CW   = 2'd1,
    STEP_CCW  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Step class for every {prev,curr} pair, two bits per entry, entry index
  // {prev[1:0],curr[1:0]}. Clockwise order is 00 -> 01 -> 11 -> 10 -> 00;
  // any pair where both bits differ is illegal.
  //   prev=00: 00 NONE, 01 CW,  10 CCW, 11 ERR
  //   prev=01: 00 CCW,  01 NONE,10 ERR, 11 CW
  //   prev=10: 00 CW,   01 ERR, 10 NONE,11 CCW
  //   prev=11: 00 ERR,  01 CCW, 10 CW,  11 NONE
  localparam logic [31:0] GRAY_STEP_LUT = 32'h1B8D_72E4;

  function automatic step_e grayStep(input logic [1:0] prevAb,
                                     input logic [1:0] currAb);
    logic [3:0] idx;
    idx = {prevAb, currAb};
    return step_e'(GRAY_STEP_LUT[{idx, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/quad_chan.sv
// One quadrature channel: input synchronisers, per-pin debounce, Gray-step
// classification and the signed position counter with its step pulses.
module quad_chan
  import quad_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DB_SAMPLES = 2,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sampleEn_i,
  input  logic                    keyA_i,
  input  logic                    keyB_i,
  input  logic [1:0]              mode_i,
  input  logic                    clr_i,
  output logic                    incPulse_o,
  output logic                    decPulse_o,
  output logic signed [CNT_W-1:0] pos_o,
  output logic                    err_o
);

  localparam logic [3:0] DB_LIMIT = 4'(DB_SAMPLES);
  localparam bit SATURATE = (WRAP == 0);
  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] POS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]              syncA_q, syncB_q;
  logic [1:0]              sampled;
  logic [1:0]              level_q, level_d;
  logic [1:0][3:0]         dbCnt_q, dbCnt_d;
  logic                    settled_q, settled_d;
  logic [1:0]              prevState_q;
  logic                    unref_q, unref_d;
  logic signed [CNT_W-1:0] pos_q, pos_d;
  logic                    err_q, err_d;
  logic                    inc_q, dec_q;

  step_e                   step;
  logic                    aChanged, aRose, modeAllows;
  logic                    stepCw, stepCcw, stepIllegal;

  // Two-flop synchronisers bring the asynchronous encoder pins into clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syncA_q <= '0;
      syncB_q <= '0;
    end else begin
      syncA_q <= {syncA_q[0], keyA_i};
      syncB_q <= {syncB_q[0], keyB_i};
    end
  end

  // Bit 1 carries A and bit 0 carries B throughout the channel.
  assign sampled = {syncA_q[1], syncB_q[1]};

  // Debounce: a pin adopts a new level only after DB_SAMPLES consecutive
  // differing samples; "settled" records whether both pins now agree with
  // the sampled inputs, which is what marks a trustworthy reference state.
  always_comb begin
    level_d   = level_q;
    dbCnt_d   = dbCnt_q;
    settled_d = settled_q;
    if (sampleEn_i) begin
      for (int p = 0; p < 2; p++) begin
        if (sampled[p] != level_q[p]) begin
          if (dbCnt_q[p] + 4'd1 == DB_LIMIT) begin
            level_d[p] = sampled[p];
            dbCnt_d[p] = 4'd0;
          end else begin
            dbCnt_d[p] = dbCnt_q[p] + 4'd1;
          end
        end else begin
          dbCnt_d[p] = 4'd0;
        end
      end
      settled_d = (level_d == sampled);
    end
  end

  // Debounced levels, stability counters and the settled flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q   <= '0;
      dbCnt_q   <= '0;
      settled_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      dbCnt_q   <= dbCnt_d;
      settled_q <= settled_d;
    end
  end

  assign step        = grayStep(prevState_q, level_q);
  assign aChanged    = prevState_q[1] ^ level_q[1];
  assign aRose       = ~prevState_q[1] & level_q[1];

  // Resolution filter. In x1 the A rising edge of a clockwise rotation
  // occurs with B high (01 -> 11), so the Gray direction is used for the
  // sign rather than the raw B level, keeping x1 in step with x2/x4.
  always_comb begin
    modeAllows = 1'b1;
    case (mode_i)
      MODE_X1: modeAllows = aRose;
      MODE_X2: modeAllows = aChanged;
      MODE_X4: modeAllows = 1'b1;
      default: modeAllows = 1'b1;
    endcase
  end

  // Until the first settled state has been absorbed as the reference,
  // state changes neither count nor flag errors.
  assign stepCw      = ~unref_q & modeAllows & (step == STEP_CW);
  assign stepCcw     = ~unref_q & modeAllows & (step == STEP_CCW);
  assign stepIllegal = ~unref_q & (step == STEP_ERR);
  assign unref_d     = unref_q & ~settled_q;

  // Next position: wrap or saturate at the limits; clear wins over a step.
  always_comb begin
    pos_d = pos_q;
    if (stepCw) begin
      if (SATURATE && (pos_q == POS_MAX)) pos_d = pos_q;
      else                                pos_d = pos_q + POS_ONE;
    end else if (stepCcw) begin
      if (SATURATE && (pos_q == POS_MIN)) pos_d = pos_q;
      else                                pos_d = pos_q - POS_ONE;
    end
    if (clr_i) pos_d = '0;
  end

  assign err_d = clr_i ? 1'b0 : (err_q | stepIllegal);

  // Step tracking and registered outputs; pulses and position move together
  // one clk after the debounced state changes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prevState_q <= '0;
      unref_q     <= 1'b1;
      pos_q       <= '0;
      err_q       <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
    end else begin
      prevState_q <= level_q;
      unref_q     <= unref_d;
      pos_q       <= pos_d;
      err_q       <= err_d;
      inc_q       <= stepCw;
      dec_q       <= stepCcw;
    end
  end

  assign incPulse_o = inc_q;
  assign decPulse_o = dec_q;
  assign pos_o      = pos_q;
  assign err_o      = err_q;

endmodule

// File: rtl/quad_decoder.sv
// Multi-channel quadrature decoder: a shared sample-tick divider feeding
// N_CH independent channel decoders.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 16,
  parameter int SAMPLE_DIV = 3000,
  parameter int DB_SAMPLES = 2,
  parameter int WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_CH-1:0]       key_a,
  input  logic [N_CH-1:0]       key_b,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       inc_pulse,
  output logic [N_CH-1:0]       dec_pulse,
  output logic [N_CH*CNT_W-1:0] pos,
  output logic [N_CH-1:0]       err
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  logic [TICK_W-1:0] tickCnt_q;
  logic              sampleEn;

  // Shared divider counting 0..SAMPLE_DIV-1; the last count is the sample tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tickCnt_q <= '0;
    end else if (tickCnt_q == TICK_LAST) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + TICK_ONE;
    end
  end

  assign sampleEn = (tickCnt_q == TICK_LAST);

  for (genvar i = 0; i < N_CH; i++) begin : gChan
    quad_chan #(
      .CNT_W      (CNT_W),
      .DB_SAMPLES (DB_SAMPLES),
      .WRAP       (WRAP)
    ) uChan (
      .clk        (clk),
      .rstn       (rstn),
      .sampleEn_i (sampleEn),
      .keyA_i     (key_a[i]),
      .keyB_i     (key_b[i]),
      .mode_i     (mode),
      .clr_i      (clr[i]),
      .incPulse_o (inc_pulse[i]),
      .decPulse_o (dec_pulse[i]),
      .pos_o      (pos[i*CNT_W +: CNT_W]),
      .err_o      (err[i])
    );
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a wrapping and a saturating instance
// share stimulus; a tick-level behavioural model predicts every pulse.
module tb_quad_decoder;

  localparam int N_CH       = 2;
  localparam int CNT_W      = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int DB_SAMPLES = 2;
  localparam int PMAX       = (1 << (CNT_W - 1)) - 1;
  localparam int PMIN       = -(1 << (CNT_W - 1));

  typedef struct packed {
    int   ch;
    logic isInc;
    int   pos;
    int   cyc;
  } evt_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [N_CH-1:0]       keyA, keyB, clr;
  logic [1:0]            mode;
  logic [N_CH-1:0]       incW, decW, errW, incS, decS, errS;
  logic [N_CH*CNT_W-1:0] posW, posS;

  quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .SAMPLE_DIV(SAMPLE_DIV),
                 .DB_SAMPLES(DB_SAMPLES), .WRAP(1)) dutW (
    .clk(clk), .rstn(rstn), .key_a(keyA), .key_b(keyB), .mode(mode),
    .clr(clr), .inc_pulse(incW), .dec_pulse(decW), .pos(posW), .err(errW));

  quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .SAMPLE_DIV(SAMPLE_DIV),
                 .DB_SAMPLES(DB_SAMPLES), .WRAP(0)) dutS (
    .clk(clk), .rstn(rstn), .key_a(keyA), .key_b(keyB), .mode(mode),
    .clr(clr), .inc_pulse(incS), .dec_pulse(decS), .pos(posS), .err(errS));

  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running edge counter used to time-stamp expected pulses.
  always @(posedge clk) cyc <= cyc + 1;

  int   nCompared = 0;
  int   nMismatched = 0;
  evt_t qW[$];
  evt_t qS[$];

  int   accA[N_CH], accB[N_CH], cntA[N_CH], cntB[N_CH];
  int   prevA[N_CH], prevB[N_CH], posWm[N_CH], posSm[N_CH];
  bit   unref[N_CH], errM[N_CH];
  int   nextSample;
  logic [N_CH-1:0] drvA, drvB;

  task automatic compare(input string name, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int grayIdx(input int a, input int b);
    if (a == 0) return (b == 0) ? 0 : 1;
    return (b == 0) ? 3 : 2;
  endfunction

  function automatic logic [1:0] cwNext(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccwNext(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int chanPos(input logic [N_CH*CNT_W-1:0] bus, input int ch);
    logic signed [CNT_W-1:0] v;
    v = bus[ch*CNT_W +: CNT_W];
    return int'(v);
  endfunction

  function automatic void resetModel();
    for (int ch = 0; ch < N_CH; ch++) begin
      accA[ch] = 0; accB[ch] = 0; cntA[ch] = 0; cntB[ch] = 0;
      prevA[ch] = 0; prevB[ch] = 0; posWm[ch] = 0; posSm[ch] = 0;
      unref[ch] = 1'b1; errM[ch] = 1'b0;
    end
  endfunction

  // One sample tick of the reference: debounce, reference capture, step
  // classification by distance around the Gray cycle, then clear.
  task automatic modelTick(input logic [N_CH-1:0] clrMask);
    for (int ch = 0; ch < N_CH; ch++) begin
      int inA, inB, d;
      bit settled, counted, isInc;
      evt_t e;
      inA = int'(drvA[ch]);
      inB = int'(drvB[ch]);
      if (inA != accA[ch]) begin
        cntA[ch]++;
        if (cntA[ch] == DB_SAMPLES) begin accA[ch] = inA; cntA[ch] = 0; end
      end else cntA[ch] = 0;
      if (inB != accB[ch]) begin
        cntB[ch]++;
        if (cntB[ch] == DB_SAMPLES) begin accB[ch] = inB; cntB[ch] = 0; end
      end else cntB[ch] = 0;
      settled = (accA[ch] == inA) && (accB[ch] == inB);
      if (unref[ch]) begin
        if (settled) unref[ch] = 1'b0;
      end else if (accA[ch] != prevA[ch] || accB[ch] != prevB[ch]) begin
        d = (grayIdx(accA[ch], accB[ch]) - grayIdx(prevA[ch], prevB[ch]) + 4) % 4;
        if (d == 2) begin
          errM[ch] = 1'b1;
        end else begin
          case (mode)
            2'b00:   counted = (prevA[ch] == 0) && (accA[ch] == 1);
            2'b01:   counted = (prevA[ch] != accA[ch]);
            default: counted = 1'b1;
          endcase
          if (counted) begin
            isInc = (d == 1);
            posWm[ch] = posWm[ch] + (isInc ? 1 : -1);
            if (posWm[ch] > PMAX) posWm[ch] -= (PMAX - PMIN + 1);
            if (posWm[ch] < PMIN) posWm[ch] += (PMAX - PMIN + 1);
            if (isInc && posSm[ch] < PMAX) posSm[ch]++;
            if (!isInc && posSm[ch] > PMIN) posSm[ch]--;
            if (clrMask[ch]) begin posWm[ch] = 0; posSm[ch] = 0; end
            e.ch = ch; e.isInc = isInc; e.cyc = cyc + 1;
            e.pos = posWm[ch]; qW.push_back(e);
            e.pos = posSm[ch]; qS.push_back(e);
          end
        end
      end
      prevA[ch] = accA[ch];
      prevB[ch] = accB[ch];
      if (clrMask[ch]) begin posWm[ch] = 0; posSm[ch] = 0; errM[ch] = 1'b0; end
    end
  endtask

  // Drive held levels up to the next sample tick, update the model, and
  // optionally pulse clr on the edge where that tick's step is registered.
  task automatic applyStimulus(input logic [N_CH-1:0] clrMask);
    keyA = drvA;
    keyB = drvB;
    while (cyc < nextSample) @(negedge clk);
    modelTick(clrMask);
    nextSample += SAMPLE_DIV;
    clr = clrMask;
    @(negedge clk);
    clr = '0;
  endtask

  task automatic holdCh(input int ch, input logic [1:0] ab, input int ticks);
    drvA[ch] = ab[1];
    drvB[ch] = ab[0];
    repeat (ticks) applyStimulus('0);
  endtask

  task automatic checkOutput(input string tag);
    for (int ch = 0; ch < N_CH; ch++) begin
      compare($sformatf("%s posW%0d", tag, ch), chanPos(posW, ch), posWm[ch]);
      compare($sformatf("%s posS%0d", tag, ch), chanPos(posS, ch), posSm[ch]);
      compare($sformatf("%s errW%0d", tag, ch), int'(errW[ch]), int'(errM[ch]));
      compare($sformatf("%s errS%0d", tag, ch), int'(errS[ch]), int'(errM[ch]));
    end
  endtask

  task automatic checkPulses(input bit isWrap, input logic [N_CH-1:0] inc,
                             input logic [N_CH-1:0] dec,
                             input logic [N_CH*CNT_W-1:0] posBus);
    string tag;
    evt_t  e;
    tag = isWrap ? "W" : "S";
    for (int ch = 0; ch < N_CH; ch++) begin
      if (inc[ch] || dec[ch]) begin
        compare($sformatf("%s excl%0d", tag, ch), int'(inc[ch] & dec[ch]), 0);
        if ((isWrap ? qW.size() : qS.size()) == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL %s unexpectedPulse ch%0d: got inc=%0d dec=%0d at cycle %0d, expected none",
                   tag, ch, inc[ch], dec[ch], cyc);
        end else begin
          e = isWrap ? qW.pop_front() : qS.pop_front();
          compare($sformatf("%s pulseCh", tag), ch, e.ch);
          compare($sformatf("%s pulseDir%0d", tag, ch), int'(inc[ch]), int'(e.isInc));
          compare($sformatf("%s pulsePos%0d", tag, ch), chanPos(posBus, ch), e.pos);
          compare($sformatf("%s pulseCyc%0d", tag, ch), cyc, e.cyc);
        end
      end
    end
  endtask

  // Monitor: every observed pulse must match the oldest predicted event.
  always @(negedge clk) begin
    checkPulses(1'b1, incW, decW, posW);
    checkPulses(1'b0, incS, decS, posS);
  end

  initial begin
    logic [1:0] cur;
    logic [1:0] cwSeq [4];
    logic [1:0] ccwSeq [4];
    logic [N_CH-1:0] mask;
    int guard;
    cwSeq  = '{2'b01, 2'b11, 2'b10, 2'b00};
    ccwSeq = '{2'b10, 2'b11, 2'b01, 2'b00};

    rstn = 1'b0; keyA = '0; keyB = '0; clr = '0; mode = 2'b10;
    drvA = '0; drvB = '0;
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("reset");
    compare("reset pulses", int'(|{incW, decW, incS, decS}), 0);
    rstn = 1'b1;
    nextSample = cyc + SAMPLE_DIV;
    holdCh(0, 2'b00, 2);

    // x4: one clockwise cycle, three ticks per level
    for (int i = 0; i < 4; i++) holdCh(0, cwSeq[i], 3);
    checkOutput("x4cw");
    compare("x4cw pos0", chanPos(posW, 0), 4);
    compare("x4cw pos1", chanPos(posW, 1), 0);

    // x1: clockwise then counter-clockwise cycle
    mode = 2'b00;
    for (int i = 0; i < 4; i++) holdCh(0, cwSeq[i], 3);
    compare("x1cw pos0", chanPos(posW, 0), 5);
    for (int i = 0; i < 4; i++) holdCh(0, ccwSeq[i], 3);
    checkOutput("x1");
    compare("x1 pos0", chanPos(posW, 0), 4);

    // one-tick glitch, then a double change
    mode = 2'b10;
    holdCh(0, 2'b10, 1);
    holdCh(0, 2'b00, 3);
    checkOutput("glitch");
    holdCh(0, 2'b11, 3);
    checkOutput("illegal");
    compare("illegal err0", int'(errW[0]), 1);
    compare("illegal pos0", chanPos(posW, 0), 4);
    applyStimulus(2'b01);
    checkOutput("clr");

    // climb to the positive limit, then cross it and come back
    cur = 2'b11;
    guard = 0;
    while (posWm[0] < PMAX && guard < 300) begin
      cur = cwNext(cur);
      holdCh(0, cur, 2);
      guard++;
    end
    compare("climb posW0", chanPos(posW, 0), 127);
    compare("climb posS0", chanPos(posS, 0), 127);
    cur = cwNext(cur);
    holdCh(0, cur, 2);
    compare("over posW0", chanPos(posW, 0), -128);
    compare("over posS0", chanPos(posS, 0), 127);
    cur = ccwNext(cur);
    holdCh(0, cur, 2);
    compare("back posW0", chanPos(posW, 0), 127);
    compare("back posS0", chanPos(posS, 0), 126);

    // clr on the same edge as a step on ch0 while ch1 also steps
    cur = cwNext(cur);
    drvA[0] = cur[1]; drvB[0] = cur[0];
    drvA[1] = 1'b0;   drvB[1] = 1'b1;
    applyStimulus('0);
    applyStimulus(2'b01);
    checkOutput("clrStep");
    compare("clrStep pos0", chanPos(posW, 0), 0);
    compare("clrStep pos1", chanPos(posW, 1), 1);

    // randomized rotation on both channels
    for (int t = 0; t < 300; t++) begin
      if (t % 25 == 0) mode = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < N_CH; ch++) begin
        int r;
        r = $urandom_range(0, 9);
        cur = {drvA[ch], drvB[ch]};
        if (r < 3)       cur = cwNext(cur);
        else if (r < 5)  cur = ccwNext(cur);
        else if (r == 5) cur = ~cur;
        drvA[ch] = cur[1];
        drvB[ch] = cur[0];
        mask[ch] = ($urandom_range(0, 15) == 0);
      end
      applyStimulus(mask);
    end
    checkOutput("random");

    // reset in the middle of a rotation with both pins high
    mode = 2'b10;
    drvA = '1; drvB = '1;
    keyA = drvA; keyB = drvB;
    @(negedge clk);
    compare("preReset qW", qW.size(), 0);
    compare("preReset qS", qS.size(), 0);
    #2 rstn = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("midReset");
    compare("midReset pulses", int'(|{incW, decW, incS, decS}), 0);
    rstn = 1'b1;
    nextSample = cyc + SAMPLE_DIV;
    repeat (3) applyStimulus('0);
    checkOutput("reref");
    holdCh(0, 2'b10, 2);
    holdCh(1, 2'b01, 2);
    compare("reref pos0", chanPos(posW, 0), 1);
    compare("reref pos1", chanPos(posW, 1), -1);
    checkOutput("final");

    repeat (4) @(negedge clk);
    compare("pending qW", qW.size(), 0);
    compare("pending qS", qS.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
